// File: rtl/ec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ec_pkg
//  Description : Shared types and constants for the encoder run controller.
//                Holds the controller state enumeration, the default
//                per-iteration watchdog limit and a small state helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4,
        ST_TOUT   = 3'd5
    } state_t;

    localparam int c_default_timeout_cyc = 1024;

    // True in the states that make up an active run. These are the states
    // where cycle_cnt advances and where abort is honoured.
    function automatic logic is_running(input state_t s);
        return (s == ST_LAUNCH) || (s == ST_WAIT) || (s == ST_GAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ec_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ec_run_ctrl_if
//  Description : Bundle of the run-controller signals.
//                master : host/channel side (drives cfg_*, abort, clr, ch_done)
//                slave  : controller side   (drives cfg_ready, ch_start,
//                         finish, timeout, iter_cnt, cycle_cnt)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ec_run_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [N_CH-1:0]   cfg_mask;
    logic [CNT_W-1:0]  cfg_iters;
    logic              abort;
    logic [N_CH-1:0]   ch_start;
    logic [N_CH-1:0]   ch_done;
    logic              finish;
    logic              timeout;
    logic [CNT_W-1:0]  iter_cnt;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              clr;

    modport master (
        output cfg_valid, cfg_mask, cfg_iters, abort, ch_done, clr,
        input  cfg_ready, ch_start, finish, timeout, iter_cnt, cycle_cnt
    );

    modport slave (
        input  cfg_valid, cfg_mask, cfg_iters, abort, ch_done, clr,
        output cfg_ready, ch_start, finish, timeout, iter_cnt, cycle_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ec_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : ec_watchdog
//  Description : Per-iteration cycle watchdog. Counts enabled cycles since the
//                last clear. expired is asserted during the enabled cycle in
//                which the count steps to TIMEOUT_CYC-1, so the owner leaves
//                its wait state after TIMEOUT_CYC-1 enabled cycles.
//  Ports       : clk, rst_n (async, active-low)
//                clear   - synchronous clear, wins over enable
//                enable  - count this cycle
//                expired - limit reached in this enabled cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module ec_watchdog
    import ec_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_default_timeout_cyc
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             c_w    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT_CYC - 2);
    localparam logic [c_w-1:0] c_max  = {c_w{1'b1}};

    logic [c_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_max)) begin
            r_count <= r_count + c_w'(1);
        end
    end

    // Decision is made on the pre-increment value so the owner sees the
    // expiry in the same cycle the count reaches its limit.
    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/ec_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ec_run_ctrl
//  Description : Encoder run controller. Accepts a run (channel mask and
//                iteration count), pulses ch_start on the masked channels,
//                collects their ch_done pulses, repeats for the requested
//                number of iterations and reports finish / timeout.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous active-low reset
//                bus    - ec_run_ctrl_if.slave: cfg_valid/cfg_ready/cfg_mask/
//                         cfg_iters, abort, clr, ch_start, ch_done, finish,
//                         timeout, iter_cnt, cycle_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module ec_run_ctrl
    import ec_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = c_default_timeout_cyc
) (
    input  logic         clk,
    input  logic         rst_n,
    ec_run_ctrl_if.slave bus
);

    state_t              r_state;
    state_t              w_state_next;

    logic [N_CH-1:0]     r_mask;
    logic [CNT_W-1:0]    r_iters;
    logic [N_CH-1:0]     r_collect;
    logic [CNT_W-1:0]    r_iter_cnt;
    logic [CNT_W-1:0]    r_cycle_cnt;

    logic                w_running;
    logic                w_accept;
    logic                w_abort;
    logic [N_CH-1:0]     w_new_done;
    logic                w_complete;
    logic [CNT_W-1:0]    w_iter_inc;
    logic                w_wd_clear;
    logic                w_wd_enable;
    logic                w_wd_expired;

    assign w_running  = is_running(r_state);
    assign w_accept   = (r_state == ST_IDLE) && bus.cfg_valid;
    assign w_abort    = w_running && bus.abort;
    assign w_new_done = bus.ch_done & r_mask;
    // An abort in the same cycle suppresses the completion so the counters
    // are left untouched on the way to TOUT.
    assign w_complete = (r_state == ST_WAIT) && !bus.abort &&
                        ((r_collect | w_new_done) == r_mask);
    assign w_iter_inc = r_iter_cnt + CNT_W'(1);

    assign w_wd_clear  = (r_state == ST_LAUNCH);
    assign w_wd_enable = (r_state == ST_WAIT);

    ec_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_wd_clear),
        .enable  (w_wd_enable),
        .expired (w_wd_expired)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    if ((bus.cfg_mask == '0) || (bus.cfg_iters == '0)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                w_state_next = bus.abort ? ST_TOUT : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.abort) begin
                    w_state_next = ST_TOUT;
                end else if (w_complete) begin
                    // Completion outranks a simultaneous watchdog expiry.
                    w_state_next = (w_iter_inc == r_iters) ? ST_DONE : ST_GAP;
                end else if (w_wd_expired) begin
                    w_state_next = ST_TOUT;
                end
            end
            ST_GAP: begin
                w_state_next = bus.abort ? ST_TOUT : ST_LAUNCH;
            end
            ST_DONE, ST_TOUT: begin
                if (bus.clr) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Run configuration, done collection and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= '0;
            r_iters     <= '0;
            r_collect   <= '0;
            r_iter_cnt  <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_mask      <= bus.cfg_mask;
                r_iters     <= bus.cfg_iters;
                r_iter_cnt  <= '0;
                r_cycle_cnt <= '0;
            end else begin
                if (w_complete) begin
                    r_iter_cnt <= w_iter_inc;
                end
                if (w_running && !w_abort && (r_cycle_cnt != {CNT_W{1'b1}})) begin
                    r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                end
            end

            if (r_state == ST_LAUNCH) begin
                r_collect <= '0;
            end else if (r_state == ST_WAIT) begin
                r_collect <= r_collect | w_new_done;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registers or state decode only
    // ------------------------------------------------------------------
    assign bus.cfg_ready = (r_state == ST_IDLE);
    assign bus.ch_start  = (r_state == ST_LAUNCH) ? r_mask : '0;
    assign bus.finish    = (r_state == ST_DONE) || (r_state == ST_TOUT);
    assign bus.timeout   = (r_state == ST_TOUT);
    assign bus.iter_cnt  = r_iter_cnt;
    assign bus.cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ec_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ec_run_ctrl
//  Description : Directed self-checking bench for ec_run_ctrl (N_CH=4,
//                CNT_W=16, TIMEOUT_CYC=16). A channel responder answers each
//                ch_start with a ch_done pulse after a programmable delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ec_run_ctrl;

    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    ec_run_ctrl_if #(.N_CH(4), .CNT_W(16)) bus ();

    ec_run_ctrl #(
        .N_CH        (4),
        .CNT_W       (16),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel responder: ch_done = (start bits & resp_mask) resp_delay cycles
    // after the start pulse, plus any always-on resp_extra bits.
    int         resp_delay = 5;
    logic [3:0] resp_mask  = 4'b1111;
    logic [3:0] resp_extra = 4'b0000;
    int         resp_cnt   = 0;
    logic [3:0] resp_bits  = 4'b0000;
    logic [3:0] resp_pulse;

    always @(negedge clk) begin
        resp_pulse = 4'b0000;
        if (resp_cnt > 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) resp_pulse = resp_bits;
        end
        if (bus.ch_start != 4'b0000) begin
            resp_cnt  = resp_delay;
            resp_bits = bus.ch_start & resp_mask;
        end
        bus.ch_done = resp_pulse | resp_extra;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    task automatic accept(input logic [3:0] m, input logic [15:0] it);
        int guard;
        guard = 0;
        while (!bus.cfg_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        bus.cfg_mask  = m;
        bus.cfg_iters = it;
        bus.cfg_valid = 1'b1;
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    // Cycle 0 is the first negedge after acceptance. Returns the cycle on
    // which finish is first seen (-1 if never), the number of start pulses,
    // how many of them differ from exp_start, and the first two start gaps.
    task automatic run_until_finish(input int max_cyc, input int abort_at,
                                    input logic [3:0] exp_start,
                                    output int fin_cyc, output int n_starts,
                                    output int n_bad, output int gap1, output int gap2);
        int last;
        fin_cyc = -1; n_starts = 0; n_bad = 0; gap1 = -1; gap2 = -1; last = -1;
        for (int t = 0; t < max_cyc; t++) begin
            bus.abort = (t == abort_at);
            if (bus.finish) begin
                fin_cyc = t;
                break;
            end
            if (bus.ch_start != 4'b0000) begin
                n_starts++;
                if (bus.ch_start !== exp_start) n_bad++;
                if (last >= 0) begin
                    if (gap1 < 0) gap1 = t - last;
                    else if (gap2 < 0) gap2 = t - last;
                end
                last = t;
            end
            @(negedge clk);
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_mask = '0; bus.cfg_iters = '0;
        bus.abort = 1'b0; bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready); end
        n_tests++; if (bus.finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b expected 0", bus.finish); end
        n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
        n_tests++; if (bus.ch_start !== 4'b0000) begin n_fail++; $display("FAIL reset_ch_start: got %b expected 0000", bus.ch_start); end
        n_tests++; if (bus.iter_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_iter_cnt: got %0d expected 0", bus.iter_cnt); end
        n_tests++; if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cycle_cnt: got %0d expected 0", bus.cycle_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal_run();
        int fc, ns, nb, g1, g2;
        resp_delay = 5; resp_mask = 4'b1111; resp_extra = 4'b0000;
        accept(4'b1011, 16'd3);
        run_until_finish(200, -1, 4'b1011, fc, ns, nb, g1, g2);
        n_tests++; if (ns != 3) begin n_fail++; $display("FAIL normal_starts: got %0d expected 3", ns); end
        n_tests++; if (nb != 0) begin n_fail++; $display("FAIL normal_start_value: got %0d wrong pulses expected 0", nb); end
        n_tests++; if (g1 != 7 || g2 != 7) begin n_fail++; $display("FAIL normal_gap: got %0d,%0d expected 7,7", g1, g2); end
        n_tests++; if (fc != 20) begin n_fail++; $display("FAIL normal_finish_cycle: got %0d expected 20", fc); end
        n_tests++; if (bus.iter_cnt !== 16'd3) begin n_fail++; $display("FAIL normal_iter_cnt: got %0d expected 3", bus.iter_cnt); end
        n_tests++; if (bus.finish !== 1'b1 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL normal_flags: got finish=%b timeout=%b expected 1,0", bus.finish, bus.timeout); end
        n_tests++; if (bus.cycle_cnt !== 16'd20) begin n_fail++; $display("FAIL normal_cycle_cnt: got %0d expected 20", bus.cycle_cnt); end
        n_tests++; if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL normal_ready_in_done: got %b expected 0", bus.cfg_ready); end
        pulse_clr();
        n_tests++; if (bus.cfg_ready !== 1'b1 || bus.finish !== 1'b0) begin n_fail++; $display("FAIL normal_clr: got ready=%b finish=%b expected 1,0", bus.cfg_ready, bus.finish); end
        n_tests++; if (bus.iter_cnt !== 16'd3) begin n_fail++; $display("FAIL normal_iter_held: got %0d expected 3", bus.iter_cnt); end
    endtask

    task automatic test_timeout();
        int fc, ns, nb, g1, g2;
        // ch1 never answers; bit2 is unmasked noise.
        resp_delay = 4; resp_mask = 4'b0001; resp_extra = 4'b0100;
        accept(4'b0011, 16'd2);
        run_until_finish(100, -1, 4'b0011, fc, ns, nb, g1, g2);
        resp_extra = 4'b0000;
        n_tests++; if (fc != 16) begin n_fail++; $display("FAIL tout_cycle: got %0d expected 16", fc); end
        n_tests++; if (bus.timeout !== 1'b1 || bus.finish !== 1'b1) begin n_fail++; $display("FAIL tout_flags: got timeout=%b finish=%b expected 1,1", bus.timeout, bus.finish); end
        n_tests++; if (bus.iter_cnt !== 16'd0) begin n_fail++; $display("FAIL tout_iter_cnt: got %0d expected 0", bus.iter_cnt); end
        n_tests++; if (bus.cycle_cnt !== 16'd16) begin n_fail++; $display("FAIL tout_cycle_cnt: got %0d expected 16", bus.cycle_cnt); end
        n_tests++; if (ns != 1) begin n_fail++; $display("FAIL tout_starts: got %0d expected 1", ns); end
        pulse_clr();
    endtask

    task automatic test_done_at_expiry();
        int fc, ns, nb, g1, g2;
        // Last done lands on the 15th WAIT cycle, the watchdog's expiry cycle.
        resp_delay = 15; resp_mask = 4'b1111; resp_extra = 4'b0000;
        accept(4'b0011, 16'd2);
        run_until_finish(100, -1, 4'b0011, fc, ns, nb, g1, g2);
        n_tests++; if (fc != 33) begin n_fail++; $display("FAIL race_finish_cycle: got %0d expected 33", fc); end
        n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL race_timeout: got %b expected 0", bus.timeout); end
        n_tests++; if (bus.iter_cnt !== 16'd2) begin n_fail++; $display("FAIL race_iter_cnt: got %0d expected 2", bus.iter_cnt); end
        n_tests++; if (g1 != 17) begin n_fail++; $display("FAIL race_gap: got %0d expected 17", g1); end
        n_tests++; if (bus.cycle_cnt !== 16'd33) begin n_fail++; $display("FAIL race_cycle_cnt: got %0d expected 33", bus.cycle_cnt); end
        pulse_clr();
        resp_delay = 5;
    endtask

    task automatic test_empty_run();
        int fc, ns, nb, g1, g2;
        accept(4'b0000, 16'd5);
        run_until_finish(10, -1, 4'b0000, fc, ns, nb, g1, g2);
        n_tests++; if (fc != 0 || ns != 0) begin n_fail++; $display("FAIL empty_mask: got finish_cycle=%0d starts=%0d expected 0,0", fc, ns); end
        n_tests++; if (bus.iter_cnt !== 16'd0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL empty_mask_state: got iter=%0d timeout=%b expected 0,0", bus.iter_cnt, bus.timeout); end
        pulse_clr();
        accept(4'b1111, 16'd0);
        run_until_finish(10, -1, 4'b0000, fc, ns, nb, g1, g2);
        n_tests++; if (fc != 0 || ns != 0) begin n_fail++; $display("FAIL empty_iters: got finish_cycle=%0d starts=%0d expected 0,0", fc, ns); end
        n_tests++; if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL empty_iters_cycle_cnt: got %0d expected 0", bus.cycle_cnt); end
        pulse_clr();
    endtask

    task automatic test_abort();
        int fc, ns, nb, g1, g2;
        resp_delay = 5; resp_mask = 4'b1111;
        accept(4'b1011, 16'd3);
        // Second WAIT spans cycles 8..12; abort in cycle 9.
        run_until_finish(100, 9, 4'b1011, fc, ns, nb, g1, g2);
        n_tests++; if (fc != 10) begin n_fail++; $display("FAIL abort_cycle: got %0d expected 10", fc); end
        n_tests++; if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL abort_timeout: got %b expected 1", bus.timeout); end
        n_tests++; if (bus.iter_cnt !== 16'd1) begin n_fail++; $display("FAIL abort_iter_cnt: got %0d expected 1", bus.iter_cnt); end
        n_tests++; if (bus.cycle_cnt !== 16'd9) begin n_fail++; $display("FAIL abort_cycle_cnt: got %0d expected 9", bus.cycle_cnt); end
        // The pending done pulse lands in TOUT and must be ignored.
        repeat (5) @(negedge clk);
        n_tests++; if (bus.iter_cnt !== 16'd1 || bus.cycle_cnt !== 16'd9) begin n_fail++; $display("FAIL abort_held: got iter=%0d cycle=%0d expected 1,9", bus.iter_cnt, bus.cycle_cnt); end
        pulse_clr();
        n_tests++; if (bus.cfg_ready !== 1'b1 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL abort_clr: got ready=%b timeout=%b expected 1,0", bus.cfg_ready, bus.timeout); end
    endtask

    task automatic test_reset_mid_run();
        int ns;
        resp_delay = 5; resp_mask = 4'b1111;
        accept(4'b1011, 16'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.cfg_ready !== 1'b1 || bus.finish !== 1'b0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got ready=%b finish=%b timeout=%b expected 1,0,0", bus.cfg_ready, bus.finish, bus.timeout); end
        n_tests++; if (bus.ch_start !== 4'b0000 || bus.iter_cnt !== 16'd0 || bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_values: got start=%b iter=%0d cycle=%0d expected 0,0,0", bus.ch_start, bus.iter_cnt, bus.cycle_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        resp_extra = 4'b1011;
        ns = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.ch_start != 4'b0000) ns++;
        end
        resp_extra = 4'b0000;
        n_tests++; if (ns != 0) begin n_fail++; $display("FAIL midrst_no_start: got %0d pulses expected 0", ns); end
        n_tests++; if (bus.iter_cnt !== 16'd0 || bus.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_after: got iter=%0d ready=%b expected 0,1", bus.iter_cnt, bus.cfg_ready); end
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_timeout();
        test_done_at_expiry();
        test_empty_run();
        test_abort();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ec_run_ctrl.md
EC_RUN_CTRL -- requirements
Module: ec_run_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of encoder channels driven.
REQ-002 SHALL have parameter CNT_W, default 16, width of the iteration and cycle counters.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, per-iteration watchdog limit in cycles; legal range 2..2^CNT_W-1.
REQ-004 SHALL have port clk, input, 1, clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1, run request.
REQ-007 SHALL have port cfg_ready, output, 1, high only in IDLE.
REQ-008 SHALL have port cfg_mask, input, N_CH, channels taking part in the run.
REQ-009 SHALL have port cfg_iters, input, CNT_W, number of iterations to run.
REQ-010 SHALL have port abort, input, 1, synchronous abort of the run.
REQ-011 SHALL have port ch_start, output, N_CH, one-cycle start pulse per channel.
REQ-012 SHALL have port ch_done, input, N_CH, one-cycle completion pulse per channel.
REQ-013 SHALL have port finish, output, 1, level; high in DONE or TOUT.
REQ-014 SHALL have port timeout, output, 1, level; high in TOUT only.
REQ-015 SHALL have port iter_cnt, output, CNT_W, number of completed iterations.
REQ-016 SHALL have port cycle_cnt, output, CNT_W, cycles spent since the run was accepted; saturates at all-ones.
REQ-017 SHALL have port clr, input, 1, returns DONE or TOUT to IDLE.

Function
REQ-018 SHALL implement states IDLE, LAUNCH, WAIT, GAP, DONE, TOUT.
REQ-019 SHALL accept a run on cfg_valid && cfg_ready.
  - On accept: latch mask and iters; clear iter_cnt and cycle_cnt.
  - If latched mask==0 or iters==0: go to DONE.
  - Otherwise: go to LAUNCH.
REQ-020 SHALL, in LAUNCH, drive ch_start = latched mask for exactly 1 cycle, clear the done-collect vector and the watchdog, then go to WAIT.
REQ-021 SHALL, in WAIT, OR ch_done & mask into a sticky collect vector; unmasked done bits and done bits in any other state are ignored.
REQ-022 SHALL, when collect|new_done covers the mask, increment iter_cnt that cycle.
  - Go to DONE if the incremented value == iters.
  - Otherwise go to GAP for 1 cycle, then LAUNCH.
  - Gap between successive start pulses = 2 cycles plus WAIT duration.
REQ-023 SHALL increment the watchdog every WAIT cycle; TOUT is entered when it reaches TIMEOUT_CYC-1 without completion.
REQ-024 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-025 SHALL increment cycle_cnt every cycle in LAUNCH, WAIT and GAP, saturating without wrap; it holds its value in DONE and TOUT.
REQ-026 SHALL, on abort in LAUNCH, WAIT or GAP, go to TOUT next cycle with counters held; abort is ignored in IDLE, DONE and TOUT.
REQ-027 SHALL, on clr in DONE or TOUT, go to IDLE next cycle; counters keep their values until the next accept.
REQ-028 SHALL drive all outputs from registers or state decode only; no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while rst_n is low, force state=IDLE, ch_start=0, iter_cnt=0, cycle_cnt=0, watchdog=0, collect=0, latched cfg=0; resulting outputs are cfg_ready=1, finish=0, timeout=0.
REQ-030 SHALL, on reset asserted mid-run, abandon the run with no further ch_start pulses after rst_n deasserts.

Structure
REQ-031 SHALL take the state enum type and a default TIMEOUT constant from shared package ec_pkg.
REQ-032 SHALL place the watchdog in sub-module ec_watchdog (ports clear, enable, expired) under parameter TIMEOUT_CYC; all other logic is inline.

Verification
REQ-033 SHALL cover this scenario: N_CH=4, mask=4'b1011, iters=3, done pulses arriving 5 cycles after each start -> three start pulses equal to 1011, iter_cnt=3, finish=1, timeout=0.
REQ-034 SHALL cover this scenario: mask=4'b0011, ch1 never reports done, TIMEOUT_CYC=16 -> TOUT after 15 WAIT cycles, timeout=1, iter_cnt=0.
REQ-035 SHALL cover this scenario: last masked done arriving on the same cycle the watchdog expires -> iteration counted, no TOUT.
REQ-036 SHALL cover this scenario: mask=0 or iters=0 -> DONE one cycle after accept, with no ch_start pulse and iter_cnt=0.
REQ-037 SHALL cover this scenario: abort during the 2nd WAIT -> TOUT with iter_cnt=1; then clr -> IDLE with cfg_ready=1.
REQ-038 SHALL cover this scenario: rst_n low during WAIT -> all outputs at reset values; done pulses after release produce no increment.
